shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multicycle FSM that drives one shift instruction (SLL/SRL/SRA, SLLV/SRLV/SRAV, LUI)
//  through the shift register (RegDesloc).
//  Drives the entry-source mux select, the shift-amount mux select and the RegDesloc
//  command, then pulses done/rd_wr.
//  The main control unit hands off with start and waits for done.
// PARAMETERS
//  SETTLE_CYCLES  1  idle cycles (shift_cmd=NOP) after the shift command, before done; legal 1..15
// PORTS
//  clk        in   1  system clock; all state updates on the rising edge
//  reset      in   1  asynchronous, active-high; forces IDLE and output reset values
//  start      in   1  request; sampled only in IDLE
//  op         in   3  shift op; latched on accepted start
//  flush      in   1  synchronous abort; any state -> IDLE next edge, no done
//  entry_sel  out  2  entry mux select: 00 IR[15:0] immediate, 01 B, 10 A
//  n_sel      out  2  amount mux select: 00 IR shamt, 01 A[4:0], 10 constant 16
//  shift_cmd  out  3  RegDesloc command: 000 NOP, 001 LOAD, 010 SLL_N, 011 SRL_N, 100 SRA_N
//  busy       out  1  high in every state except IDLE
//  done       out  1  one-cycle pulse in DONE
//  rd_wr      out  1  one-cycle pulse in DONE; register-file write of the shift result
//  err        out  1  one-cycle pulse, the cycle after start accepted with op=111
// BEHAVIOUR
//  Reset values: state=IDLE, op_q=000, cnt=0.
//    All outputs 0 (entry_sel=00, n_sel=00, shift_cmd=NOP).
//  Op table (op -> entry_sel, n_sel, shift cmd):
//    000 SLL  -> 01,00,010
//    001 SRL  -> 01,00,011
//    010 SRA  -> 01,00,100
//    011 SLLV -> 01,01,010
//    100 SRLV -> 01,01,011
//    101 SRAV -> 01,01,100
//    110 LUI  -> 00,10,010
//    111 illegal
//  States: IDLE -> LOAD -> SHIFT -> SETTLE -> DONE -> IDLE.
//    IDLE:   start=1 with a legal op latches op_q and goes to LOAD.
//            op=111 stays in IDLE and pulses err next cycle.
//    LOAD:   shift_cmd=LOAD; entry_sel from op_q.
//    SHIFT:  shift_cmd from op_q; n_sel from op_q.
//    SETTLE: shift_cmd=NOP for SETTLE_CYCLES cycles; cnt 4-bit down-counter.
//    DONE:   done=1, rd_wr=1, shift_cmd=NOP; next state always IDLE.
//  entry_sel and n_sel are driven from op_q and held from LOAD through DONE.
//    They are 00 in IDLE.
//  Latency: start accepted at edge 0; LOAD after edge 0; done high the cycle after
//    edge 2+SETTLE_CYCLES. Default: 4th cycle after the accepting edge.
//  start while busy: ignored, not queued. start in the DONE cycle: ignored; resample in IDLE.
//  flush has priority over start and every transition.
//    flush in DONE: done still shows this cycle, then IDLE.
//  Async reset mid-operation: outputs go to reset values immediately, no done pulse.
//  Shift amount 0 (shamt=0 or A[4:0]=0): identical sequence; RegDesloc passes the value.
//  All outputs are decoded from registered state/op_q (Moore); no combinational path from start.
// STRUCTURE
//  Shared package shift_pkg holds:
//    localparams for the op codes, the shift_cmd encodings, the entry_sel and n_sel encodings,
//    and the state encoding.
//  One sub-module: shift_op_decode, combinational op_q -> {entry_sel, n_sel, cmd, legal}.
//    Reused by the main control unit for illegal-op detection.
//  Top: state register, op_q register, settle counter, Moore output decode.
// TESTING
//  1. reset high mid-SHIFT, then low:
//     -> all outputs 0 immediately; IDLE; next start accepted normally.
//  2. start, op=000 (SLL), SETTLE_CYCLES=1:
//     -> cycle+1 entry_sel=01, shift_cmd=001
//     -> cycle+2 shift_cmd=010, n_sel=00
//     -> cycle+3 NOP
//     -> cycle+4 done=rd_wr=1; busy low on cycle+5.
//  3. op=101 (SRAV) and op=110 (LUI):
//     -> SRAV: n_sel=01, shift_cmd=100, entry_sel=01
//     -> LUI:  entry_sel=00, n_sel=10, shift_cmd=010.
//  4. start with op=111:
//     -> err=1 one cycle; busy stays 0; no LOAD issued.
//  5. start re-asserted during LOAD/SHIFT/DONE:
//     -> ignored; exactly one done per accepted start; op_q unchanged.
//  6. flush in SETTLE with SETTLE_CYCLES=3:
//     -> IDLE next edge; done never pulses; shift_cmd=NOP.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer: op codes, RegDesloc commands,
// mux selects and FSM state encoding.
package shift_pkg;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_SLLV = 3'b011;
    localparam logic [2:0] OP_SRLV = 3'b100;
    localparam logic [2:0] OP_SRAV = 3'b101;
    localparam logic [2:0] OP_LUI  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_SLL_N = 3'b010;
    localparam logic [2:0] CMD_SRL_N = 3'b011;
    localparam logic [2:0] CMD_SRA_N = 3'b100;

    localparam logic [1:0] ENTRY_IMM = 2'b00;
    localparam logic [1:0] ENTRY_B   = 2'b01;
    localparam logic [1:0] ENTRY_A   = 2'b10;

    localparam logic [1:0] NSEL_SHAMT = 2'b00;
    localparam logic [1:0] NSEL_A     = 2'b01;
    localparam logic [1:0] NSEL_16    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational op decode: shift op -> entry/amount mux selects, RegDesloc
// shift command and a legality flag.
module shift_op_decode
    import shift_pkg::*;
(
    input  logic [2:0] i_op,
    output logic [1:0] o_entry_sel,
    output logic [1:0] o_n_sel,
    output logic [2:0] o_cmd,
    output logic       o_legal
);

    always_comb begin
        o_entry_sel = ENTRY_B;
        o_n_sel     = NSEL_SHAMT;
        o_cmd       = CMD_NOP;
        o_legal     = 1'b1;
        case (i_op)
            OP_SLL:  o_cmd = CMD_SLL_N;
            OP_SRL:  o_cmd = CMD_SRL_N;
            OP_SRA:  o_cmd = CMD_SRA_N;
            OP_SLLV: begin o_n_sel = NSEL_A; o_cmd = CMD_SLL_N; end
            OP_SRLV: begin o_n_sel = NSEL_A; o_cmd = CMD_SRL_N; end
            OP_SRAV: begin o_n_sel = NSEL_A; o_cmd = CMD_SRA_N; end
            OP_LUI: begin
                o_entry_sel = ENTRY_IMM;
                o_n_sel     = NSEL_16;
                o_cmd       = CMD_SLL_N;
            end
            default: begin
                o_entry_sel = ENTRY_IMM;
                o_legal     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle controller that walks one shift instruction through RegDesloc
// (load, shift, settle) and then pulses done/rd_wr. Outputs are Moore.
//
//  state  | meaning
//  IDLE   | waiting for start; outputs all zero
//  LOAD   | RegDesloc loads the entry-mux operand
//  SHIFT  | RegDesloc shifts by the selected amount
//  SETTLE | NOP for SETTLE_CYCLES cycles
//  DONE   | done/rd_wr pulse, then back to IDLE
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [2:0] i_op,
    input  logic       i_flush,
    output logic [1:0] o_entry_sel,
    output logic [1:0] o_n_sel,
    output logic [2:0] o_shift_cmd,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_rd_wr,
    output logic       o_err
);

    localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_op_q;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       w_op_load;

    logic [2:0] w_dec_op;
    logic [1:0] w_dec_entry_sel;
    logic [1:0] w_dec_n_sel;
    logic [2:0] w_dec_cmd;
    logic       w_dec_legal;

    // One decoder serves both jobs: legality of the incoming op while idle,
    // and the mux/command decode of the latched op while busy.
    assign w_dec_op = (r_state == ST_IDLE) ? i_op : r_op_q;

    shift_op_decode u_decode (
        .i_op        (w_dec_op),
        .o_entry_sel (w_dec_entry_sel),
        .o_n_sel     (w_dec_n_sel),
        .o_cmd       (w_dec_cmd),
        .o_legal     (w_dec_legal)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_op_q  <= OP_SLL;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            if (w_op_load) begin
                r_op_q <= i_op;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        w_op_load   = 1'b0;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_dec_legal) begin
                            w_op_load   = 1'b1;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                ST_LOAD:  w_state_nxt = ST_SHIFT;
                ST_SHIFT: begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = LP_SETTLE_LAST;
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                ST_DONE:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_entry_sel = ENTRY_IMM;
        o_n_sel     = NSEL_SHAMT;
        o_shift_cmd = CMD_NOP;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_rd_wr     = 1'b0;
        if (r_state != ST_IDLE) begin
            o_entry_sel = w_dec_entry_sel;
            o_n_sel     = w_dec_n_sel;
            o_busy      = 1'b1;
        end
        case (r_state)
            ST_LOAD:  o_shift_cmd = CMD_LOAD;
            ST_SHIFT: o_shift_cmd = w_dec_cmd;
            ST_DONE: begin
                o_done  = 1'b1;
                o_rd_wr = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_err = r_err;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: two instances (settle 1 and settle 3),
// output bundle {entry_sel, n_sel, shift_cmd, busy, done, rd_wr, err} checked.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       flush1 = 1'b0;
    logic       start3 = 1'b0;
    logic       flush3 = 1'b0;
    logic [2:0] op = 3'b000;

    logic [1:0] es1, ns1, es3, ns3;
    logic [2:0] cmd1, cmd3;
    logic       busy1, done1, wr1, err1;
    logic       busy3, done3, wr3, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start1), .i_op(op), .i_flush(flush1),
        .o_entry_sel(es1), .o_n_sel(ns1), .o_shift_cmd(cmd1), .o_busy(busy1),
        .o_done(done1), .o_rd_wr(wr1), .o_err(err1)
    );

    shift_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_start(start3), .i_op(op), .i_flush(flush3),
        .o_entry_sel(es3), .o_n_sel(ns3), .o_shift_cmd(cmd3), .o_busy(busy3),
        .o_done(done3), .o_rd_wr(wr3), .o_err(err3)
    );

    wire [10:0] obs1 = {es1, ns1, cmd1, busy1, done1, wr1, err1};
    wire [10:0] obs3 = {es3, ns3, cmd3, busy3, done3, wr3, err3};

    localparam logic [10:0] IDLE0 = 11'b00_00_000_0_0_0_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick();
        chk("reset_d1", obs1, IDLE0);
        chk("reset_d3", obs3, IDLE0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", obs1, IDLE0);

        // SLL, settle 1
        op = 3'b000; start1 = 1'b1;
        tick(); start1 = 1'b0;
        chk("sll_load",   obs1, 11'b01_00_001_1_0_0_0);
        tick(); chk("sll_shift",  obs1, 11'b01_00_010_1_0_0_0);
        tick(); chk("sll_settle", obs1, 11'b01_00_000_1_0_0_0);
        tick(); chk("sll_done",   obs1, 11'b01_00_000_1_1_1_0);
        tick(); chk("sll_idle",   obs1, IDLE0);

        // SRAV
        op = 3'b101; start1 = 1'b1;
        tick(); start1 = 1'b0;
        chk("srav_load",  obs1, 11'b01_01_001_1_0_0_0);
        tick(); chk("srav_shift", obs1, 11'b01_01_100_1_0_0_0);
        tick(); tick();
        chk("srav_done", obs1, 11'b01_01_000_1_1_1_0);
        tick(); chk("srav_idle", obs1, IDLE0);

        // LUI
        op = 3'b110; start1 = 1'b1;
        tick(); start1 = 1'b0;
        chk("lui_load",   obs1, 11'b00_10_001_1_0_0_0);
        tick(); chk("lui_shift",  obs1, 11'b00_10_010_1_0_0_0);
        tick(); chk("lui_settle", obs1, 11'b00_10_000_1_0_0_0);
        tick(); chk("lui_done",   obs1, 11'b00_10_000_1_1_1_0);
        tick(); chk("lui_idle",   obs1, IDLE0);

        // illegal op
        op = 3'b111; start1 = 1'b1;
        tick(); start1 = 1'b0;
        chk("ill_err",  obs1, 11'b00_00_000_0_0_0_1);
        tick(); chk("ill_err_clear", obs1, IDLE0);

        // start held through the whole op, op changed mid-flight
        op = 3'b001; start1 = 1'b1;
        tick();
        chk("hold_load", obs1, 11'b01_00_001_1_0_0_0);
        op = 3'b011;
        tick(); chk("hold_shift_opq", obs1, 11'b01_00_011_1_0_0_0);
        tick(); chk("hold_settle",    obs1, 11'b01_00_000_1_0_0_0);
        tick(); chk("hold_done",      obs1, 11'b01_00_000_1_1_1_0);
        tick(); chk("hold_idle_after_done", obs1, IDLE0);
        start1 = 1'b0;
        tick(); chk("hold_no_requeue", obs1, IDLE0);

        // flush beats start in IDLE, and suppresses err
        op = 3'b010; start1 = 1'b1; flush1 = 1'b1;
        tick(); chk("flush_idle_start", obs1, IDLE0);
        op = 3'b111;
        tick(); chk("flush_idle_ill", obs1, IDLE0);
        start1 = 1'b0; flush1 = 1'b0;

        // flush in DONE: done still visible, then IDLE
        op = 3'b100; start1 = 1'b1;
        tick(); start1 = 1'b0;
        tick(); chk("srlv_shift", obs1, 11'b01_01_011_1_0_0_0);
        tick(); tick();
        flush1 = 1'b1;
        chk("flush_done_visible", obs1, 11'b01_01_000_1_1_1_0);
        tick(); flush1 = 1'b0;
        chk("flush_done_idle", obs1, IDLE0);

        // async reset mid-SHIFT
        op = 3'b010; start1 = 1'b1;
        tick(); start1 = 1'b0;
        tick(); chk("rst_pre_shift", obs1, 11'b01_00_100_1_0_0_0);
        #2 rst = 1'b1;
        #1 chk("rst_async_zero", obs1, IDLE0);
        tick(); rst = 1'b0;
        tick(); chk("rst_idle", obs1, IDLE0);
        op = 3'b000; start1 = 1'b1;
        tick(); start1 = 1'b0;
        chk("rst_restart_load", obs1, 11'b01_00_001_1_0_0_0);
        tick(); tick(); tick(); tick();
        chk("rst_restart_idle", obs1, IDLE0);

        // settle 3: full run
        op = 3'b011; start3 = 1'b1;
        tick(); start3 = 1'b0;
        chk("s3_load", obs3, 11'b01_01_001_1_0_0_0);
        tick(); chk("s3_shift",   obs3, 11'b01_01_010_1_0_0_0);
        tick(); tick(); tick();
        chk("s3_settle_last", obs3, 11'b01_01_000_1_0_0_0);
        tick(); chk("s3_done", obs3, 11'b01_01_000_1_1_1_0);
        tick(); chk("s3_idle", obs3, IDLE0);

        // settle 3: flush in SETTLE
        op = 3'b000; start3 = 1'b1;
        tick(); start3 = 1'b0;
        tick(); tick(); tick();
        chk("s3f_settle", obs3, 11'b01_00_000_1_0_0_0);
        flush3 = 1'b1;
        tick(); flush3 = 1'b0;
        chk("s3f_idle", obs3, IDLE0);
        tick(); chk("s3f_no_done1", obs3, IDLE0);
        tick(); chk("s3f_no_done2", obs3, IDLE0);
        chk("d1_quiet", obs1, IDLE0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
